// File: rtl/pong_ball_engine.sv
// Pong ball controller: moves the ball on the board grid, bounces it off the walls,
// resolves paddle hits/misses at the goal columns and raises hit/point pulses.
module pong_ball_engine #(
  parameter int c_game_width    = 40,
  parameter int c_game_height   = 30,
  parameter int c_coord_w       = 6,
  parameter int c_ball_speed    = 1250000,
  parameter int c_speed_step    = 62500,
  parameter int c_min_period    = 250000,
  parameter int c_paddle_height = 6,
  parameter int c_hold_ticks    = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_game_active,
  input  logic [c_coord_w-1:0] i_paddle_y_p1,
  input  logic [c_coord_w-1:0] i_paddle_y_p2,
  input  logic [c_coord_w-1:0] i_col_count_div,
  input  logic [c_coord_w-1:0] i_row_count_div,
  output logic                 o_draw_ball,
  output logic [c_coord_w-1:0] o_ball_x,
  output logic [c_coord_w-1:0] o_ball_y,
  output logic                 o_hit,
  output logic                 o_p1_point,
  output logic                 o_p2_point,
  output logic                 o_serving
);

  localparam int c_per_w  = $clog2(c_ball_speed + 2);
  localparam int c_hold_w = $clog2(c_hold_ticks + 1);

  localparam logic [c_coord_w-1:0] c_x_mid     = c_coord_w'(c_game_width / 2);
  localparam logic [c_coord_w-1:0] c_y_mid     = c_coord_w'(c_game_height / 2);
  localparam logic [c_coord_w-1:0] c_x_last    = c_coord_w'(c_game_width - 1);
  localparam logic [c_coord_w-1:0] c_x_right   = c_coord_w'(c_game_width - 2);
  localparam logic [c_coord_w-1:0] c_x_rebound = c_coord_w'(c_game_width - 3);
  localparam logic [c_coord_w-1:0] c_y_last    = c_coord_w'(c_game_height - 1);
  localparam logic [c_coord_w-1:0] c_y_prev    = c_coord_w'(c_game_height - 2);
  localparam logic [c_coord_w-1:0] c_one       = c_coord_w'(1);
  localparam logic [c_coord_w-1:0] c_two       = c_coord_w'(2);
  localparam logic [c_per_w-1:0]   c_per_init  = c_per_w'(c_ball_speed);
  localparam logic [c_per_w-1:0]   c_per_min   = c_per_w'(c_min_period);
  localparam logic [c_per_w-1:0]   c_per_step  = c_per_w'(c_speed_step);
  localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(c_hold_ticks - 1);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORE} state_t;

  state_t                 state_q, state_d;
  logic [c_coord_w-1:0]   x_q, x_d, y_q, y_d;
  logic                   dir_right_q, dir_right_d;
  logic                   dir_down_q, dir_down_d;
  logic [c_per_w-1:0]     period_q, period_d;
  logic [c_per_w-1:0]     cnt_q, cnt_d;
  logic [c_hold_w-1:0]    hold_q, hold_d;
  logic                   hit_q, hit_d;
  logic                   p1_point_q, p1_point_d;
  logic                   p2_point_q, p2_point_d;
  logic                   draw_q, draw_d;
  logic                   tick;

  // Paddle span compared one bit wider so top + length cannot wrap at the grid edge.
  function automatic logic paddle_hit(input logic [c_coord_w-1:0] pad,
                                      input logic [c_coord_w-1:0] y);
    logic [c_coord_w:0] top;
    logic [c_coord_w:0] bot;
    logic [c_coord_w:0] yy;
    top = {1'b0, pad};
    bot = top + (c_coord_w + 1)'(c_paddle_height - 1);
    yy  = {1'b0, y};
    return (yy >= top) && (yy <= bot);
  endfunction

  function automatic logic [c_per_w-1:0] faster(input logic [c_per_w-1:0] per);
    if (32'(per) >= 32'(c_min_period + c_speed_step)) return per - c_per_step;
    return c_per_min;
  endfunction

  assign tick = (cnt_q == period_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    period_d    = period_q;
    cnt_d       = tick ? '0 : cnt_q + c_per_w'(1);
    hold_d      = hold_q;
    hit_d       = 1'b0;
    p1_point_d  = 1'b0;
    p2_point_d  = 1'b0;
    draw_d      = (i_row_count_div == y_q) && (i_col_count_div == x_q);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        x_d   = c_x_mid;
        y_d   = c_y_mid;
        if (i_game_active) begin
          state_d = SERVE;
          hold_d  = '0;
        end
      end
      SERVE: begin
        x_d = c_x_mid;
        y_d = c_y_mid;
        if (tick) begin
          if (hold_q == c_hold_last) begin
            state_d = PLAY;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + c_hold_w'(1);
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (!dir_down_q && y_q == '0) begin
            dir_down_d = 1'b1;
            y_d        = c_one;
          end else if (dir_down_q && y_q == c_y_last) begin
            dir_down_d = 1'b0;
            y_d        = c_y_prev;
          end else begin
            y_d = dir_down_q ? y_q + c_one : y_q - c_one;
          end

          if (!dir_right_q && x_q == c_one) begin
            if (paddle_hit(i_paddle_y_p1, y_q)) begin
              dir_right_d = 1'b1;
              x_d         = c_two;
              hit_d       = 1'b1;
              period_d    = faster(period_q);
            end else begin
              x_d        = '0;
              p2_point_d = 1'b1;
              state_d    = SCORE;
              hold_d     = '0;
            end
          end else if (dir_right_q && x_q == c_x_right) begin
            if (paddle_hit(i_paddle_y_p2, y_q)) begin
              dir_right_d = 1'b0;
              x_d         = c_x_rebound;
              hit_d       = 1'b1;
              period_d    = faster(period_q);
            end else begin
              x_d        = c_x_last;
              p1_point_d = 1'b1;
              state_d    = SCORE;
              hold_d     = '0;
            end
          end else begin
            x_d = dir_right_q ? x_q + c_one : x_q - c_one;
          end
        end
      end
      SCORE: begin
        if (tick) begin
          if (hold_q == c_hold_last) begin
            // Serve toward whoever conceded: a ball parked in column 0 got past P1.
            dir_right_d = (x_q != '0);
            dir_down_d  = 1'b0;
            x_d         = c_x_mid;
            y_d         = c_y_mid;
            period_d    = c_per_init;
            state_d     = SERVE;
            hold_d      = '0;
          end else begin
            hold_d = hold_q + c_hold_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_game_active) begin
      state_d    = IDLE;
      x_d        = c_x_mid;
      y_d        = c_y_mid;
      period_d   = c_per_init;
      cnt_d      = '0;
      hold_d     = '0;
      hit_d      = 1'b0;
      p1_point_d = 1'b0;
      p2_point_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      x_q         <= c_x_mid;
      y_q         <= c_y_mid;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b0;
      period_q    <= c_per_init;
      cnt_q       <= '0;
      hold_q      <= '0;
      hit_q       <= 1'b0;
      p1_point_q  <= 1'b0;
      p2_point_q  <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hit_q       <= hit_d;
      p1_point_q  <= p1_point_d;
      p2_point_q  <= p2_point_d;
      draw_q      <= draw_d;
    end
  end

  assign o_draw_ball = draw_q;
  assign o_ball_x    = x_q;
  assign o_ball_y    = y_q;
  assign o_hit       = hit_q;
  assign o_p1_point  = p1_point_q;
  assign o_p2_point  = p2_point_q;
  assign o_serving   = (state_q == SERVE) || (state_q == SCORE);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine on an 8x6 board with a 4-clock starting step period.
module tb_pong_ball_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       ga;
  logic [3:0] p1_y, p2_y, col, row;
  logic       draw, hit, p1_pt, p2_pt, serving;
  logic [3:0] bx, by;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pong_ball_engine #(
    .c_game_width(8), .c_game_height(6), .c_coord_w(4), .c_ball_speed(3),
    .c_speed_step(1), .c_min_period(1), .c_paddle_height(2), .c_hold_ticks(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_game_active(ga),
    .i_paddle_y_p1(p1_y), .i_paddle_y_p2(p2_y),
    .i_col_count_div(col), .i_row_count_div(row),
    .o_draw_ball(draw), .o_ball_x(bx), .o_ball_y(by),
    .o_hit(hit), .o_p1_point(p1_pt), .o_p2_point(p2_pt), .o_serving(serving)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(bx), 32'(ex));
    check({tag, ".y"}, 32'(by), 32'(ey));
  endtask

  task automatic check_pulses(input string tag, input logic eh, input logic e1, input logic e2);
    check({tag, ".hit"}, 32'(hit), 32'(eh));
    check({tag, ".p1pt"}, 32'(p1_pt), 32'(e1));
    check({tag, ".p2pt"}, 32'(p2_pt), 32'(e2));
  endtask

  initial begin
    rst = 1'b1; ga = 1'b0; p1_y = 4'd0; p2_y = 4'd0; col = 4'd0; row = 4'd0;
    step(2);
    check_ball("rst", 4, 3);
    check("rst.serving", 32'(serving), 0);
    check("rst.draw", 32'(draw), 0);
    check_pulses("rst", 0, 0, 0);

    // IDLE still draws the centred ball
    rst = 1'b0; col = 4'd4; row = 4'd3;
    step(1);
    check("idle.draw", 32'(draw), 1);
    check("idle.serving", 32'(serving), 0);
    check_ball("idle", 4, 3);

    // Serve: two ticks of four clocks each
    col = 4'd0; row = 4'd0; ga = 1'b1;
    step(1);
    check("serve.start", 32'(serving), 1);
    step(7);
    check("serve.end", 32'(serving), 1);
    check_ball("serve.end", 4, 3);
    step(1);
    check("play.serving", 32'(serving), 0);
    step(3);
    check_ball("play.wait", 4, 3);
    col = 4'd5; row = 4'd2;
    step(1);
    check_ball("play.t1", 5, 2);
    check("draw.early", 32'(draw), 0);
    step(1);
    check("draw.hit", 32'(draw), 1);
    row = 4'd3;
    step(1);
    check("draw.miss", 32'(draw), 0);
    col = 4'd0; row = 4'd0;
    step(2);
    check_ball("play.t2", 6, 1);

    // Right paddle at rows 0..1 returns the ball; period 3 -> 2
    step(4);
    check_ball("hit1", 5, 0);
    check_pulses("hit1", 1, 0, 0);
    step(1);
    check("hit1.pulse_end", 32'(hit), 0);
    step(1);
    check("hit1.spacing3", 32'(bx), 5);
    step(1);
    check_ball("wall.top", 4, 1);

    // Left paddle top edge at row 4; period 2 -> 1
    p1_y = 4'd4;
    step(9);
    check_ball("approach.left", 1, 4);
    step(2);
    check("hit2.not_early", 32'(bx), 1);
    step(1);
    check_ball("hit2", 2, 5);
    check("hit2.pulse", 32'(hit), 1);
    step(1);
    check("hit2.pulse_end", 32'(hit), 0);
    check("hit2.spacing2a", 32'(bx), 2);
    step(1);
    check_ball("wall.bottom", 3, 4);

    // Third hit: period already at floor, spacing stays 2 clocks
    step(8);
    check_ball("hit3", 5, 0);
    check("hit3.pulse", 32'(hit), 1);
    step(1);
    check("hit3.floor", 32'(bx), 5);
    step(1);
    check_ball("hit3.next", 4, 1);

    // Left paddle rows 2..3 just misses y=4: P2 scores
    p1_y = 4'd2; p2_y = 4'd4;
    step(8);
    check_ball("miss.left", 0, 5);
    check_pulses("miss.left", 0, 0, 1);
    check("score.serving", 32'(serving), 1);
    step(1);
    check("miss.left.pulse_end", 32'(p2_pt), 0);
    step(2);
    check_ball("score.frozen", 0, 5);
    step(1);
    check_ball("score.recentre", 4, 3);
    check("score.to_serve", 32'(serving), 1);
    step(7);
    check("serve2.end", 32'(serving), 1);
    step(1);
    check("serve2.play", 32'(serving), 0);
    step(3);
    check_ball("serve2.period", 4, 3);
    step(1);
    check_ball("serve2.dir_left", 3, 2);

    // Miss at x=1 while bouncing off the top wall on the same tick
    step(12);
    check_ball("miss.corner", 0, 1);
    check("miss.corner.p2pt", 32'(p2_pt), 1);
    step(1);
    check("miss.corner.end", 32'(p2_pt), 0);
    check("score2.serving", 32'(serving), 1);

    // Reset in the middle of SCORE
    rst = 1'b1;
    step(1);
    check_ball("rst2", 4, 3);
    check("rst2.serving", 32'(serving), 0);
    check_pulses("rst2", 0, 0, 0);
    rst = 1'b0;
    step(1);
    check("rst2.serve", 32'(serving), 1);
    step(12);
    check_ball("rst2.dir", 5, 2);

    // Right paddle rows 4..5 misses y=1: P1 scores, serve goes right
    step(8);
    check_ball("miss.right", 7, 0);
    check_pulses("miss.right", 0, 1, 0);
    step(1);
    check("miss.right.end", 32'(p1_pt), 0);
    step(7);
    check_ball("score3.recentre", 4, 3);
    step(12);
    check_ball("serve3.dir_right", 5, 2);

    // Drop game_active mid-PLAY
    step(1);
    ga = 1'b0;
    step(1);
    check_ball("drop", 4, 3);
    check("drop.serving", 32'(serving), 0);
    check_pulses("drop", 0, 0, 0);
    step(5);
    check_ball("idle.hold", 4, 3);
    check("idle.hold.serving", 32'(serving), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
